// File: rtl/axi_ddr_slave_model.sv
// Block-RAM-backed AXI4 slave standing in for the DDR3 controller.
// Independent write and read engines, one burst in flight on each.
// Bursts must be 4-byte beats, FIXED or INCR; anything else answers SLVERR
// without touching memory (reads return zero data).
module axi_ddr_slave_model #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int MEM_AW = 12
) (
    input  logic                ui_clk,
    input  logic                ui_clk_sync_rst,
    input  logic [ID_W-1:0]     S_AXI_AWID,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic [2:0]          S_AXI_AWSIZE,
    input  logic [1:0]          S_AXI_AWBURST,
    input  logic                S_AXI_AWLOCK,
    input  logic [3:0]          S_AXI_AWCACHE,
    input  logic [2:0]          S_AXI_AWPROT,
    input  logic [3:0]          S_AXI_AWQOS,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WLAST,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [ID_W-1:0]     S_AXI_BID,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ID_W-1:0]     S_AXI_ARID,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic [2:0]          S_AXI_ARSIZE,
    input  logic [1:0]          S_AXI_ARBURST,
    input  logic                S_AXI_ARLOCK,
    input  logic [3:0]          S_AXI_ARCACHE,
    input  logic [2:0]          S_AXI_ARPROT,
    input  logic [3:0]          S_AXI_ARQOS,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [ID_W-1:0]     S_AXI_RID,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY,
    output logic [15:0]         wr_burst_cnt,
    output logic [15:0]         rd_burst_cnt
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // Captured burst context; err marks an illegal size/burst type.
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [MEM_AW-1:0] idx;
        logic [7:0]        len;
        logic [7:0]        beat;
        logic              err;
        logic              incr;
    } burst_t;

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

    w_state_t w_state;
    r_state_t r_state;
    burst_t   wb;
    burst_t   rb;
    logic     w_past;   // a beat beyond AWLEN has been accepted
    logic     ram_we;

    // Address bits above the RAM window and the sideband fields are don't-care.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWADDR[ADDR_W-1:MEM_AW+2], S_AXI_AWADDR[1:0],
                             S_AXI_ARADDR[ADDR_W-1:MEM_AW+2], S_AXI_ARADDR[1:0],
                             S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                             S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS};

    // Beats past AWLEN and illegal bursts never reach the RAM.
    assign ram_we = !ui_clk_sync_rst && (w_state == W_DATA) && S_AXI_WVALID
                    && !wb.err && !w_past;

    // RAM write port with byte enables; contents survive reset.
    always_ff @(posedge ui_clk) begin
        if (ram_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (S_AXI_WSTRB[b]) mem[wb.idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // Write engine: accept address, absorb beats until WLAST, then respond.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            w_state       <= W_IDLE;
            wb            <= '0;
            w_past        <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            S_AXI_BRESP   <= RESP_OKAY;
            wr_burst_cnt  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        wb.id         <= S_AXI_AWID;
                        wb.idx        <= S_AXI_AWADDR[MEM_AW+1:2];
                        wb.len        <= S_AXI_AWLEN;
                        wb.beat       <= 8'd0;
                        wb.err        <= (S_AXI_AWSIZE != 3'd2) || (S_AXI_AWBURST > 2'd1);
                        wb.incr       <= (S_AXI_AWBURST == 2'd1);
                        w_past        <= 1'b0;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_DATA;
                    end else begin
                        S_AXI_AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (S_AXI_WVALID) begin
                        if (wb.incr) wb.idx <= wb.idx + MEM_AW'(1);
                        wb.beat <= wb.beat + 8'd1;
                        if (wb.beat == wb.len) w_past <= 1'b1;
                        if (S_AXI_WLAST) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BID    <= wb.id;
                            S_AXI_BRESP  <= (wb.err || w_past || (wb.beat != wb.len))
                                            ? RESP_SLVERR : RESP_OKAY;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        wr_burst_cnt  <= wr_burst_cnt + 16'd1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read engine: one fetch cycle per beat, R outputs held until RREADY.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_state       <= R_IDLE;
            rb            <= '0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RID     <= '0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RLAST   <= 1'b0;
            rd_burst_cnt  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        rb.id         <= S_AXI_ARID;
                        rb.idx        <= S_AXI_ARADDR[MEM_AW+1:2];
                        rb.len        <= S_AXI_ARLEN;
                        rb.beat       <= 8'd0;
                        rb.err        <= (S_AXI_ARSIZE != 3'd2) || (S_AXI_ARBURST > 2'd1);
                        rb.incr       <= (S_AXI_ARBURST == 2'd1);
                        S_AXI_ARREADY <= 1'b0;
                        r_state       <= R_FETCH;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_FETCH: begin
                    S_AXI_RDATA  <= rb.err ? '0 : mem[rb.idx];
                    S_AXI_RRESP  <= rb.err ? RESP_SLVERR : RESP_OKAY;
                    S_AXI_RID    <= rb.id;
                    S_AXI_RLAST  <= (rb.beat == rb.len);
                    S_AXI_RVALID <= 1'b1;
                    r_state      <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        S_AXI_RLAST  <= 1'b0;
                        if (S_AXI_RLAST) begin
                            rd_burst_cnt  <= rd_burst_cnt + 16'd1;
                            S_AXI_ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            if (rb.incr) rb.idx <= rb.idx + MEM_AW'(1);
                            rb.beat <= rb.beat + 8'd1;
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ddr_slave_model.sv
// Self-checking bench for axi_ddr_slave_model: directed cases plus random
// bursts, compared against a word-array memory model and expected-response queues.
module tb_axi_ddr_slave_model;

    localparam int WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  awid = '0, arid = '0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0;
    logic        awvalid = 1'b0, arvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [15:0] wr_cnt, rd_cnt;

    axi_ddr_slave_model dut (
        .ui_clk(clk), .ui_clk_sync_rst(rst),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'h3), .S_AXI_AWPROT(3'h0), .S_AXI_AWQOS(4'h0),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'h3), .S_AXI_ARPROT(3'h0), .S_AXI_ARQOS(4'h0),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .wr_burst_cnt(wr_cnt), .rd_burst_cnt(rd_cnt)
    );

    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [WORDS];
    rbeat_t      exp_r [$];
    bexp_t       exp_b [$];
    int          exp_wr_cnt = 0;
    int          exp_rd_cnt = 0;
    logic [31:0] r_log [$];
    logic [1:0]  last_rresp, last_bresp;
    logic [3:0]  last_rid;
    logic [31:0] wdat [512];
    logic [3:0]  wstb [512];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: counters every cycle, B/R payloads on each handshake, R hold on stalls.
    logic        prev_stall = 1'b0;
    logic [39:0] prev_r;
    always @(negedge clk) begin
        bexp_t  eb;
        rbeat_t er;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("wr_burst_cnt", 64'(wr_cnt), 64'(exp_wr_cnt[15:0]));
            check("rd_burst_cnt", 64'(rd_cnt), 64'(exp_rd_cnt[15:0]));
            if (prev_stall) check("r_hold", 64'({rvalid, rlast, rresp, rid, rdata}), 64'(prev_r));
            if (bvalid && bready) begin
                check("b_expected", 64'(exp_b.size() > 0), 64'(1));
                if (exp_b.size() > 0) begin
                    eb = exp_b.pop_front();
                    check("bid", 64'(bid), 64'(eb.id));
                    check("bresp", 64'(bresp), 64'(eb.resp));
                end
                last_bresp = bresp;
                exp_wr_cnt++;
            end
            if (rvalid && rready) begin
                check("r_expected", 64'(exp_r.size() > 0), 64'(1));
                if (exp_r.size() > 0) begin
                    er = exp_r.pop_front();
                    check("rid", 64'(rid), 64'(er.id));
                    check("rdata", 64'(rdata), 64'(er.data));
                    check("rresp", 64'(rresp), 64'(er.resp));
                    check("rlast", 64'(rlast), 64'(er.last));
                end
                r_log.push_back(rdata);
                last_rresp = rresp;
                last_rid   = rid;
                if (rlast) exp_rd_cnt++;
            end
            prev_stall = rvalid && !rready;
            prev_r     = {rvalid, rlast, rresp, rid, rdata};
        end
    end

    // Write burst from wdat/wstb; model memory is updated once the burst has completed.
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input int nbeats, input bit gaps);
        bit    legal = (size == 3'd2) && (burst <= 2'd1);
        int    base  = int'(addr[13:2]);
        int    n;
        int    idx;
        bexp_t e;
        e.id   = id;
        e.resp = (!legal || nbeats != len + 1) ? 2'b10 : 2'b00;
        exp_b.push_back(e);
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 200) begin @(negedge clk); n++; end
        check("aw_timeout", 64'(awready), 64'(1));
        @(posedge clk); #1 awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clk); #1;
            end
            wvalid = 1'b1; wdata = wdat[i]; wstrb = wstb[i]; wlast = (i == nbeats - 1);
            n = 0;
            @(negedge clk);
            if (i == 0) check("aw_to_wready", 64'({awready, wready}), 64'(2'b01));
            while (!wready && n < 200) begin @(negedge clk); n++; end
            check("w_timeout", 64'(wready), 64'(1));
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        check("wlast_to_bvalid", 64'({wready, bvalid}), 64'(2'b01));
        @(posedge clk); #1;
        if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 200) begin @(negedge clk); n++; end
        check("b_timeout", 64'(bvalid), 64'(1));
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        check("b_to_awready", 64'(awready), 64'(1));
        @(posedge clk); #1;
        for (int i = 0; i < nbeats; i++) begin
            if (legal && i <= len) begin
                idx = (base + ((burst == 2'd1) ? i : 0)) % WORDS;
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) mdl[idx][8*b +: 8] = wdat[i][8*b +: 8];
            end
        end
    endtask

    // Read burst; expected beats are a snapshot of the model at request time.
    // rmode: 0 RREADY high, 1 toggling every cycle, 2 random.
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [2:0] size, input logic [1:0] burst, input int rmode);
        bit     legal = (size == 3'd2) && (burst <= 2'd1);
        int     base  = int'(addr[13:2]);
        int     n, cyc, got;
        bit     prev_nonlast;
        rbeat_t e;
        for (int i = 0; i <= len; i++) begin
            e.id   = id;
            e.data = legal ? mdl[(base + ((burst == 2'd1) ? i : 0)) % WORDS] : 32'h0;
            e.resp = legal ? 2'b00 : 2'b10;
            e.last = (i == len);
            exp_r.push_back(e);
        end
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 200) begin @(negedge clk); n++; end
        check("ar_timeout", 64'(arready), 64'(1));
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk);
        check("ar_to_fetch", 64'({arready, rvalid}), 64'(2'b00));
        @(posedge clk); #1;
        cyc = 0; got = 0; prev_nonlast = 1'b0;
        while (got <= len && cyc < 4000) begin
            rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (cyc == 0) check("ar_to_rvalid", 64'(rvalid), 64'(1));
            if (prev_nonlast) check("r_beat_gap", 64'(rvalid), 64'(0));
            prev_nonlast = 1'b0;
            if (rvalid && rready) begin
                got++;
                prev_nonlast = (got <= len);
            end
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b0;
        check("r_beats", 64'(got), 64'(len + 1));
        @(negedge clk);
        check("rlast_to_arready", 64'(arready), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] prior [16];
        logic [31:0] old_a, old_b, addr;
        int          len, nb, wc, rc;
        logic [2:0]  size;
        logic [1:0]  burst;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs",
              64'({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast}),
              64'(0));
        check("reset_counters", 64'({wr_cnt, rd_cnt}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after_reset", 64'({awready, arready}), 64'(2'b11));
        @(posedge clk); #1;

        // Fill the whole memory so every later read has a known expectation
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
            write_burst(4'(b), 32'(b * 1024), 255, 3'd2, 2'd1, 256, 1'b0);
        end

        // Single write then read
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        write_burst(4'd1, 32'h100, 0, 3'd2, 2'd1, 1, 1'b0);
        check("single_bresp", 64'(last_bresp), 64'(0));
        r_log.delete();
        read_burst(4'd5, 32'h100, 0, 3'd2, 2'd1, 0);
        check("single_rdata", 64'(r_log[0]), 64'(32'hDEADBEEF));
        check("single_rid", 64'(last_rid), 64'(5));
        check("single_rresp", 64'(last_rresp), 64'(0));

        // INCR 16 beats with alternating strobes, RREADY toggling
        for (int i = 0; i < 16; i++) begin
            prior[i] = mdl[i];
            wdat[i]  = 32'(i) * 32'h01010101;
            wstb[i]  = (i % 2 == 1) ? 4'h3 : 4'hF;
        end
        write_burst(4'd2, 32'h0, 15, 3'd2, 2'd1, 16, 1'b1);
        r_log.delete();
        read_burst(4'd3, 32'h0, 15, 3'd2, 2'd1, 1);
        check("incr16_beats", 64'(r_log.size()), 64'(16));
        check("incr16_beat4", 64'(r_log[4]), 64'(32'h04040404));
        check("incr16_beat15", 64'(r_log[15]), 64'({prior[15][31:16], 16'h0F0F}));

        // FIXED write collapses onto one word
        old_a = mdl[32'h44 >> 2];
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
        write_burst(4'd4, 32'h40, 3, 3'd2, 2'd0, 4, 1'b0);
        r_log.delete();
        read_burst(4'd6, 32'h40, 1, 3'd2, 2'd1, 2);
        check("fixed_beat0", 64'(r_log[0]), 64'(4));
        check("fixed_beat1", 64'(r_log[1]), 64'(old_a));

        // Illegal AWSIZE: SLVERR, memory untouched
        old_a = mdl[32'h200 >> 2];
        wdat[0] = 32'h12345678; wstb[0] = 4'hF;
        write_burst(4'd7, 32'h200, 0, 3'd1, 2'd1, 1, 1'b0);
        check("badsize_bresp", 64'(last_bresp), 64'(2'b10));
        r_log.delete();
        read_burst(4'd7, 32'h200, 0, 3'd2, 2'd1, 0);
        check("badsize_mem", 64'(r_log[0]), 64'(old_a));

        // WRAP read: four zero beats with SLVERR
        r_log.delete();
        read_burst(4'd8, 32'h0, 3, 3'd2, 2'd2, 0);
        check("wrap_beats", 64'(r_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) check("wrap_rdata", 64'(r_log[i]), 64'(0));
        check("wrap_rresp", 64'(last_rresp), 64'(2'b10));

        // Early WLAST on beat 1 of a len-3 burst
        old_a = mdl[(32'h300 >> 2) + 2];
        old_b = mdl[(32'h300 >> 2) + 3];
        wdat[0] = 32'hA0A0A0A0; wdat[1] = 32'hA1A1A1A1; wstb[0] = 4'hF; wstb[1] = 4'hF;
        write_burst(4'd9, 32'h300, 3, 3'd2, 2'd1, 2, 1'b0);
        check("early_bresp", 64'(last_bresp), 64'(2'b10));
        r_log.delete();
        read_burst(4'd10, 32'h300, 3, 3'd2, 2'd1, 0);
        check("early_w0", 64'(r_log[0]), 64'(32'hA0A0A0A0));
        check("early_w1", 64'(r_log[1]), 64'(32'hA1A1A1A1));
        check("early_w2", 64'(r_log[2]), 64'(old_a));
        check("early_w3", 64'(r_log[3]), 64'(old_b));

        // Simultaneous read and write of one word: read sees the old value
        old_a = mdl[32'h500 >> 2];
        wc = exp_wr_cnt; rc = exp_rd_cnt;
        wdat[0] = 32'hCAFEF00D; wstb[0] = 4'hF;
        r_log.delete();
        fork
            write_burst(4'd11, 32'h500, 0, 3'd2, 2'd1, 1, 1'b0);
            read_burst(4'd12, 32'h500, 0, 3'd2, 2'd1, 0);
        join
        check("simul_old", 64'(r_log[0]), 64'(old_a));
        check("simul_wr_cnt", 64'(wr_cnt), 64'(16'(wc + 1)));
        check("simul_rd_cnt", 64'(rd_cnt), 64'(16'(rc + 1)));
        r_log.delete();
        read_burst(4'd13, 32'h500, 0, 3'd2, 2'd1, 0);
        check("simul_new", 64'(r_log[0]), 64'(32'hCAFEF00D));

        // Reset in the middle of an 8-beat read
        for (int i = 0; i < 8; i++) begin
            rbeat_t e;
            e.id = 4'd14; e.data = mdl[(32'h800 >> 2) + i]; e.resp = 2'b00; e.last = (i == 7);
            exp_r.push_back(e);
        end
        arid = 4'd14; araddr = 32'h800; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        @(negedge clk);
        check("rst_ar_ready", 64'(arready), 64'(1));
        @(posedge clk); #1 arvalid = 1'b0; rready = 1'b1;
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        @(negedge clk);
        check("rst_mid_rvalid", 64'({rvalid, arready, awready}), 64'(0));
        check("rst_mid_counters", 64'({wr_cnt, rd_cnt}), 64'(0));
        exp_r.delete(); exp_b.delete();
        exp_wr_cnt = 0; exp_rd_cnt = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_release_arready", 64'(arready), 64'(1));
        @(posedge clk); #1;
        r_log.delete();
        read_burst(4'd15, 32'h800, 7, 3'd2, 2'd1, 0);
        check("post_rst_beats", 64'(r_log.size()), 64'(8));

        // Random traffic: aliased addresses, wrap at top of memory, illegal and odd-length bursts
        for (int t = 0; t < 60; t++) begin
            addr  = $urandom;
            addr  = addr & 32'hFFFF_FFFC;
            if (t % 7 == 0) addr = 32'h0000_3FF0;
            len   = $urandom_range(0, 15);
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            burst = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, len + 3) : len + 1;
                for (int i = 0; i < nb; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
                write_burst(4'($urandom), addr, len, size, burst, nb, 1'b1);
            end else begin
                read_burst(4'($urandom), addr, len, size, burst, $urandom_range(0, 2));
            end
        end

        repeat (3) @(posedge clk);
        check("exp_b_drained", 64'(exp_b.size()), 64'(0));
        check("exp_r_drained", 64'(exp_r.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound in case the DUT wedges the handshake loops.
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_ddr_slave_model.md
# axi_ddr_slave_model

AXI4 memory-mapped slave that answers the burst traffic the GMII packet engine issues on its M_AXI master port. It is an on-chip, block-RAM-backed stand-in for the MIG DDR3 controller, used for DDR-less builds and for simulation. It sits in the `ui_clk` domain, and its write and read channels run independently, each with one burst in flight.

## Interface
- `ADDR_W`, 32: AXI address width.
- `DATA_W`, 32: data width. Fixed at 32; the only legal transfer size is 4 bytes.
- `ID_W`, 4: AXI ID width.
- `MEM_AW`, 12: log2 of memory depth in words. Word index = `ADDR[MEM_AW+1:2]`; higher address bits are ignored, so addresses alias.

Ports:
- `ui_clk`  in  1  sole clock, 100 MHz.
- `ui_clk_sync_rst`  in  1  synchronous, active-high reset.
- `S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST`  in  ID_W/ADDR_W/8/3/2  write address.
- `S_AXI_AWLOCK/AWCACHE/AWPROT/AWQOS`  in  1/4/3/4  ignored.
- `S_AXI_AWVALID`  in  1;  `S_AXI_AWREADY`  out  1.
- `S_AXI_WDATA/WSTRB/WLAST/WVALID`  in  32/4/1/1;  `S_AXI_WREADY`  out  1.
- `S_AXI_BID/BRESP/BVALID`  out  ID_W/2/1;  `S_AXI_BREADY`  in  1.
- `S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST`  in  ID_W/ADDR_W/8/3/2  read address.
- `S_AXI_ARLOCK/ARCACHE/ARPROT/ARQOS`  in  1/4/3/4  ignored.
- `S_AXI_ARVALID`  in  1;  `S_AXI_ARREADY`  out  1.
- `S_AXI_RID/RDATA/RRESP/RLAST/RVALID`  out  ID_W/32/2/1/1;  `S_AXI_RREADY`  in  1.
- `wr_burst_cnt`  out  16  count of completed B handshakes; wraps.
- `rd_burst_cnt`  out  16  count of completed RLAST handshakes; wraps.

## Operation
- Storage is a dual-port RAM of 2^MEM_AW × 32. The write port has per-byte enables from WSTRB. The read port has 1-cycle registered read. RAM contents are not cleared by reset.
- Burst legality:
  - Legal bursts have SIZE = 2 and BURST = FIXED (0) or INCR (1).
  - Any other SIZE, or BURST = WRAP or reserved, is illegal. The response is SLVERR (2'b10), no RAM writes occur, and reads return RDATA = 0.
- Address stepping: INCR adds 4 bytes per beat, wrapping modulo memory size. FIXED repeats the same address.
- Write FSM, W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: AWREADY = 1. On AW handshake, capture ID, address, length and error flag; clear the beat counter.
  - W_DATA: WREADY = 1. Each W handshake writes the RAM (if legal) and advances the address and counter. The burst ends on the beat with WLAST = 1.
  - If WLAST arrives on a beat index ≠ AWLEN, BRESP = SLVERR. Beats up to and including the WLAST beat are still written. Beats past AWLEN are not written.
  - W_RESP: BVALID = 1, BID = captured ID. Leave on BREADY and increment `wr_burst_cnt`.
- Read FSM, R_IDLE → R_FETCH → R_DATA:
  - R_IDLE: ARREADY = 1. On AR handshake, capture fields and clear the beat counter.
  - R_FETCH: drive the RAM read address for one cycle.
  - R_DATA: RVALID = 1, RID = captured ID, RRESP = OKAY or SLVERR, RLAST = (beat == ARLEN). Hold all R outputs stable until RREADY.
  - On handshake: if RLAST, go to R_IDLE and increment `rd_burst_cnt`; else advance the address and return to R_FETCH.
  - An illegal read still returns ARLEN+1 beats.
- A read and a write to the same word in the same cycle: the read returns the old data (read-first).
- Reset, including mid-burst: on the next edge both FSMs go to IDLE, the in-flight burst is abandoned with no response, and the counters clear.

## Timing
- While reset is asserted, all outputs are 0. AWREADY and ARREADY rise on the first cycle after reset deasserts. All outputs are registered.
- Write path, AW handshake at cycle N:
  - AWREADY = 0 and WREADY = 1 from N+1.
  - WLAST handshake at M → WREADY = 0 and BVALID = 1 at M+1.
  - B handshake at K → AWREADY = 1 at K+1.
  - A single-beat write takes 3 cycles from AW handshake to the next AWREADY.
- Read path, AR handshake at N:
  - ARREADY = 0 from N+1; RVALID = 1 with data at N+2.
  - Non-last R handshake at K → RVALID = 0 at K+1 and 1 at K+2. Throughput is 1 beat per 2 cycles.
  - Last-beat handshake at K → ARREADY = 1 at K+1.
- No combinational path from any input to any output.

## Test plan
- Single write then read: AW 0x100 len 0, W 0xDEADBEEF strb 0xF; then AR 0x100 → BRESP 0, RDATA 0xDEADBEEF, RLAST = 1, RRESP 0, RID equals ARID.
- INCR len 15 at 0x0, data i·0x01010101, WSTRB alternating 0xF/0x3, then read back with RREADY toggling every cycle → 16 beats. Odd beats have the upper two bytes unchanged from the prior contents. RLAST appears only on beat 15.
- FIXED len 3 write at 0x40 with data 1,2,3,4; then INCR read len 1 at 0x40 → beat 0 returns 4, beat 1 returns the old word at 0x44.
- Error cases:
  - AWSIZE = 1 → BRESP 2'b10, memory unchanged on readback.
  - ARBURST = WRAP with len 3 → 4 beats, RDATA 0, RRESP 2'b10.
  - Early WLAST on beat 1 of a len-3 burst → BRESP 2'b10; words 0 and 1 written, words 2 and 3 untouched.
- Simultaneous traffic: read and write to the same address in the same cycle → the read returns the old value, and `wr_burst_cnt` and `rd_burst_cnt` each increment by 1.
- Reset asserted mid-way through an 8-beat read → next cycle RVALID = 0, counters 0, ARREADY = 1 after release. A subsequent read completes normally.
